mix_columns_seq: RTL
====================

Name: mix_columns_seq

Overview:
Column-serial AES MixColumns/InvMixColumns stage that sits directly downstream of ShiftRows in the round datapath.
- Accepts a 128-bit state over a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock and presents the registered result on an output valid/ready handshake.
- Trades latency for GF(2^8) multiplier area; i_fDec selects encrypt (MixColumns) or decrypt (InvMixColumns).

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; others unsupported.

Ports:
i_Clk  input  1  clock, all state on rising edge
i_Rst  input  1  asynchronous, active-low reset
i_Valid  input  1  input state valid
o_Ready  output  1  block can accept a state
i_Text  input  128  state from ShiftRows
i_fDec  input  1  1 = InvMixColumns, 0 = MixColumns; sampled with i_Text
o_Valid  output  1  o_Text holds a finished result
i_Ready  input  1  downstream accepts result
o_Text  output  128  transformed state, registered

Behaviour:
- State byte layout: byte k = i_Text[127-8k -: 8], column-major.
  - Column c = bytes 4c..4c+3, i.e. bits [127-32c -: 32].
  - Row r of column c is byte 4c+r; row 0 is the MSB byte.
- Forward transform, per column: circulant matrix [02 03 01 01].
  - Inverse transform: [0E 0B 0D 09].
  - Arithmetic is GF(2^8) with reduction polynomial 0x11B (xtime: shift left, XOR 0x1B on carry out).
- FSM states IDLE, RUN, DONE.
  - IDLE: o_Ready=1, o_Valid=0.
    - On i_Valid=1: latch i_Text into working register, latch i_Fdec into fDec_q, clear column counter, go to RUN.
  - RUN: o_Ready=0.
    - Each cycle, columns cnt .. cnt+COLS_PER_CYCLE-1 of the working register are replaced in place by their transform using fDec_q; cnt advances by COLS_PER_CYCLE.
    - After the cycle that processes column 3, go to DONE.
  - DONE: o_Valid=1, o_Text = working register, o_Ready=0.
    - o_Text stays stable while i_Ready=0.
    - On i_Ready=1, go to IDLE the next cycle.
- Latency:
  - Accept edge at T; o_Valid rises at T + 4/COLS_PER_CYCLE edges (4, 2 or 1 cycles).
  - Throughput is one state per 4/COLS_PER_CYCLE + 2 cycles.
- i_Valid, i_Text and i_fDec are ignored outside IDLE. No new state is accepted in the same cycle as the output handshake.
- o_Text reflects only the working register. Partially transformed content must never be flagged valid.
- Reset (any time, including mid-RUN or DONE):
  - Asynchronously forces IDLE; o_Ready=1 once deasserted.
  - o_Valid=0, o_Text=128'h0, counter=0, fDec_q=0.
  - Any in-flight state is discarded.
- The counter is 2 bits, with no wrap-around beyond column 3 (RUN exits on the last column).

Optional Feature:
MIXCOL_LASTRND_BYPASS_EN
- Defined:
  - Adds input port i_fLast (1 bit, sampled with i_Text).
  - If i_fLast=1 at accept, the FSM goes IDLE->DONE directly; o_Text = i_Text unchanged and o_Valid rises one edge after accept. This supports the AES final round, which omits MixColumns.
  - i_fLast=0 gives normal behaviour.
- Undefined: port i_fLast does not exist; every accepted state is transformed.

Test Plan:
- Forward, COLS_PER_CYCLE=1: column 0 = db 13 53 45, others = 01 01 01 01, i_fDec=0 -> o_Text column 0 = 8e 4d a1 bc, others 01 01 01 01; o_Valid exactly 4 cycles after accept.
- Inverse: column 0 = 8e 4d a1 bc, column 1 = 9f dc 58 9d, columns 2-3 = c6 c6 c6 c6, i_fDec=1 -> columns db 13 53 45, f2 0a 22 5c, c6 c6 c6 c6, c6 c6 c6 c6.
- Backpressure: hold i_Ready=0 for 10 cycles after o_Valid -> o_Text and o_Valid stable and o_Ready=0 throughout; one cycle after i_Ready=1, o_Valid=0 and o_Ready=1.
- Parameter sweep COLS_PER_CYCLE=2 and 4 with the forward vector -> identical o_Text; latency 2 and 1 cycles respectively.
- Reset mid-RUN: assert i_Rst=0 after 2 processing cycles -> immediately o_Valid=0, o_Text=0, o_Ready=1; a following fresh accept produces the correct result.
- With MIXCOL_LASTRND_BYPASS_EN: i_fLast=1, i_Text=00112233_44556677_8899aabb_ccddeeff -> same value on o_Text, o_Valid one cycle after accept.

Source files
------------

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module  : mix_columns_seq
// Brief   : Column-serial AES MixColumns / InvMixColumns stage with
//           valid/ready handshakes on both sides. COLS_PER_CYCLE (1, 2, 4)
//           columns are transformed in place per clock.
//           Optional: MIXCOL_LASTRND_BYPASS_EN adds i_fLast, which passes a
//           final-round state through untransformed.
// Revision: 1.0 - initial release
// ============================================================================
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Text,
  input  logic         i_fDec,
`ifdef MIXCOL_LASTRND_BYPASS_EN
  input  logic         i_fLast,
`endif
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [127:0] o_Text
);

  // With four columns per cycle the step truncates to zero and cnt stays at 0.
  localparam logic [1:0] C_STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] C_LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       r_state;
  logic [127:0] r_work;
  logic [1:0]   r_cnt;
  logic         r_dec;
  logic         r_valid;
  logic         r_ready;

  logic         w_bypass;
  logic [31:0]  w_cols     [4];
  logic [31:0]  w_cols_nxt [4];
  logic [31:0]  w_mixed    [COLS_PER_CYCLE];
  logic [127:0] w_work_nxt;

`ifdef MIXCOL_LASTRND_BYPASS_EN
  assign w_bypass = i_fLast;
`else
  assign w_bypass = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // The inverse matrix factors as the forward matrix times [05 00 04 00],
  // so decryption only adds a cheap pre-mix ahead of the shared forward path.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic dec);
    logic [7:0] a0, a1, a2, a3, u, v, t;
    {a0, a1, a2, a3} = col;
    if (dec) begin
      u  = xtime(xtime(a0 ^ a2));
      v  = xtime(xtime(a1 ^ a3));
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    t = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1),
            a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3),
            a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_cols[i] = r_work[127 - 32*i -: 32];
    end
  end

  generate
    for (genvar j = 0; j < int'(COLS_PER_CYCLE); j++) begin : g_col
      logic [1:0] w_sel;
      assign w_sel      = r_cnt + 2'(j);
      assign w_mixed[j] = mix_col(w_cols[w_sel], r_dec);
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_cols_nxt[i] = w_cols[i];
    end
    for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
      w_cols_nxt[r_cnt + 2'(j)] = w_mixed[j];
    end
    w_work_nxt = {w_cols_nxt[0], w_cols_nxt[1], w_cols_nxt[2], w_cols_nxt[3]};
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state <= IDLE;
      r_work  <= 128'h0;
      r_cnt   <= 2'd0;
      r_dec   <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_Valid) begin
            r_work  <= i_Text;
            r_dec   <= i_fDec;
            r_cnt   <= 2'd0;
            r_ready <= 1'b0;
            if (w_bypass) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt + C_STEP;
          if (r_cnt == C_LAST_CNT) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_Ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_Text  = r_work;
  assign o_Valid = r_valid;
  assign o_Ready = r_ready;

endmodule
`default_nettype wire
